// File: rtl/frame_buffer_pool_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frame_buffer_pool_pkg                                                    |
// | Display geometry, pixel format and buffer ownership states.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package frame_buffer_pool_pkg;

  localparam int COLOR_BITS     = 12;
  localparam int DISPLAY_WIDTH  = 160;
  localparam int DISPLAY_HEIGHT = 120;
  localparam int ADDR_BITS      = 15;
  localparam int FB_DEPTH       = DISPLAY_WIDTH * DISPLAY_HEIGHT;

  typedef enum logic [1:0] {
    FB_FREE    = 2'd0,
    FB_WRITING = 2'd1,
    FB_READY   = 2'd2,
    FB_DISPLAY = 2'd3
  } fb_state_t;

endpackage
`default_nettype wire

// File: rtl/frame_buffer_pool_allocator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frame_buffer_pool_allocator                                              |
// | Buffer ownership control: writer / ready / display indices and handoff.  |
// | Optional statistics counters under macro FB_STATS_EN.                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module frame_buffer_pool_allocator
  import frame_buffer_pool_pkg::*;
#(
  parameter int NUM_BUFFERS = 3,
  parameter int IDX_LEN     = $clog2(NUM_BUFFERS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_done,
  input  logic               frame_start,
  output logic               write_ready,
  output logic [IDX_LEN-1:0] write_buf_idx,
  output logic [IDX_LEN-1:0] display_idx,
  output logic [15:0]        frames_dropped,
  output logic [15:0]        frames_repeated
);

  logic [IDX_LEN-1:0] display_q, display_d;
  logic [IDX_LEN-1:0] ready_q, ready_d;
  logic [IDX_LEN-1:0] write_idx_q, write_idx_d;
  logic               ready_valid_q, ready_valid_d;
  logic               write_ready_q, write_ready_d;
  logic               done_accepted;
  logic               need_buffer;
  fb_state_t          buf_state [NUM_BUFFERS];

  assign done_accepted = frame_done && write_ready_q;

  always_comb begin
    display_d     = display_q;
    ready_d       = ready_q;
    ready_valid_d = ready_valid_q;
    write_idx_d   = write_idx_q;
    write_ready_d = write_ready_q;

    // frame_start consumes the pre-cycle READY before frame_done can replace it.
    if (frame_start && ready_valid_q) begin
      display_d     = ready_q;
      ready_valid_d = 1'b0;
    end
    if (done_accepted) begin
      ready_d       = write_idx_q;
      ready_valid_d = 1'b1;
    end

    for (int i = 0; i < NUM_BUFFERS; i++) begin
      buf_state[i] = FB_FREE;
      if (IDX_LEN'(i) == display_d)                         buf_state[i] = FB_DISPLAY;
      else if (ready_valid_d && IDX_LEN'(i) == ready_d)     buf_state[i] = FB_READY;
      else if (write_ready_q && !done_accepted &&
               IDX_LEN'(i) == write_idx_q)                  buf_state[i] = FB_WRITING;
    end

    need_buffer = done_accepted || (!write_ready_q && frame_start && ready_valid_q);
    if (need_buffer) begin
      write_ready_d = 1'b0;
      // Descending scan so the lowest free index is the last one taken.
      for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
        if (buf_state[i] == FB_FREE) begin
          write_idx_d   = IDX_LEN'(i);
          write_ready_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      display_q     <= '0;
      ready_q       <= '0;
      write_idx_q   <= IDX_LEN'(1);
      ready_valid_q <= 1'b0;
      write_ready_q <= 1'b1;
    end else begin
      display_q     <= display_d;
      ready_q       <= ready_d;
      write_idx_q   <= write_idx_d;
      ready_valid_q <= ready_valid_d;
      write_ready_q <= write_ready_d;
    end
  end

  assign write_ready   = write_ready_q;
  assign write_buf_idx = write_idx_q;
  assign display_idx   = display_q;

`ifdef FB_STATS_EN
  logic [15:0] dropped_q, dropped_d;
  logic [15:0] repeated_q, repeated_d;

  always_comb begin
    dropped_d  = dropped_q;
    repeated_d = repeated_q;
    if (done_accepted && ready_valid_q && !frame_start && dropped_q != 16'hFFFF)
      dropped_d = dropped_q + 16'd1;
    if (frame_start && !ready_valid_q && repeated_q != 16'hFFFF)
      repeated_d = repeated_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dropped_q  <= '0;
      repeated_q <= '0;
    end else begin
      dropped_q  <= dropped_d;
      repeated_q <= repeated_d;
    end
  end

  assign frames_dropped  = dropped_q;
  assign frames_repeated = repeated_q;
`else
  assign frames_dropped  = '0;
  assign frames_repeated = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | xilinx_true_dual_port_read_first_1_clock_ram                             |
// | Single-clock block RAM: port A writes, port B reads with output register.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module xilinx_true_dual_port_read_first_1_clock_ram #(
  parameter int RAM_WIDTH = 12,
  parameter int RAM_DEPTH = 1024,
  parameter int ADDR_LEN  = 10
) (
  input  logic                 clka,
  input  logic [ADDR_LEN-1:0]  addra,
  input  logic [RAM_WIDTH-1:0] dina,
  input  logic                 ena,
  input  logic                 wea,
  input  logic [ADDR_LEN-1:0]  addrb,
  input  logic                 enb,
  input  logic                 rstb,
  input  logic                 regceb,
  output logic [RAM_WIDTH-1:0] doutb
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data_q;
  logic [RAM_WIDTH-1:0] doutb_q;

  always_ff @(posedge clka) begin
    if (ena && wea) mem[addra] <= dina;
  end

  always_ff @(posedge clka) begin
    if (enb) ram_data_q <= mem[addrb];
  end

  // Only the output register is resettable, matching the BRAM primitive.
  always_ff @(posedge clka) begin
    if (rstb)        doutb_q <= '0;
    else if (regceb) doutb_q <= ram_data_q;
  end

  assign doutb = doutb_q;

endmodule
`default_nettype wire

// File: rtl/frame_buffer_pool.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frame_buffer_pool                                                        |
// | N-way tear-free framebuffer between pixel writer and scan-out reader.    |
// | Optional statistics counters under macro FB_STATS_EN.                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module frame_buffer_pool
  import frame_buffer_pool_pkg::*;
#(
  parameter  int WIDTH       = COLOR_BITS,
  parameter  int DEPTH       = FB_DEPTH,
  parameter  int ADDR_LEN    = ADDR_BITS,
  parameter  int NUM_BUFFERS = 3,
  localparam int IDX_LEN     = $clog2(NUM_BUFFERS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                write_enable,
  input  logic [ADDR_LEN-1:0] write_addr,
  input  logic [WIDTH-1:0]    write_data,
  input  logic                frame_done,
  output logic                write_ready,
  output logic [IDX_LEN-1:0]  write_buf_idx,
  input  logic                frame_start,
  input  logic [ADDR_LEN-1:0] read_addr,
  output logic [WIDTH-1:0]    read_data,
  output logic [IDX_LEN-1:0]  read_buf_idx,
  output logic [15:0]         frames_dropped,
  output logic [15:0]         frames_repeated
);

  logic [IDX_LEN-1:0] display_idx;
  logic [IDX_LEN-1:0] rd_idx1_q, rd_idx1_d;
  logic [IDX_LEN-1:0] rd_idx2_q, rd_idx2_d;
  logic [WIDTH-1:0]   bank_dout [NUM_BUFFERS];

  frame_buffer_pool_allocator #(
    .NUM_BUFFERS (NUM_BUFFERS),
    .IDX_LEN     (IDX_LEN)
  ) u_allocator (
    .clk             (clk),
    .rst             (rst),
    .frame_done      (frame_done),
    .frame_start     (frame_start),
    .write_ready     (write_ready),
    .write_buf_idx   (write_buf_idx),
    .display_idx     (display_idx),
    .frames_dropped  (frames_dropped),
    .frames_repeated (frames_repeated)
  );

  for (genvar i = 0; i < NUM_BUFFERS; i++) begin : g_bank
    logic bank_we;
    assign bank_we = write_enable && write_ready && (write_buf_idx == IDX_LEN'(i));

    xilinx_true_dual_port_read_first_1_clock_ram #(
      .RAM_WIDTH (WIDTH),
      .RAM_DEPTH (DEPTH),
      .ADDR_LEN  (ADDR_LEN)
    ) u_ram (
      .clka   (clk),
      .addra  (write_addr),
      .dina   (write_data),
      .ena    (1'b1),
      .wea    (bank_we),
      .addrb  (read_addr),
      .enb    (1'b1),
      .rstb   (rst),
      .regceb (1'b1),
      .doutb  (bank_dout[i])
    );
  end

  // Index delay matches the two BRAM read stages so the mux tracks the data.
  always_comb begin
    rd_idx1_d = display_idx;
    rd_idx2_d = rd_idx1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_idx1_q <= '0;
      rd_idx2_q <= '0;
    end else begin
      rd_idx1_q <= rd_idx1_d;
      rd_idx2_q <= rd_idx2_d;
    end
  end

  assign read_buf_idx = rd_idx2_q;

  always_comb begin
    read_data = '0;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      if (rd_idx2_q == IDX_LEN'(i)) read_data = bank_dout[i];
    end
  end

endmodule
`default_nettype wire
